// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: multi-cycle multiply/divide unit with HI/LO registers and
// stall request for the MIPS EX stage. Results are computed at the start
// edge into a pending register and committed after a fixed latency.
// Optional feature macro: MDU_MADD_EN (md_op 7 = signed multiply-accumulate).
module muldiv_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        d_md_use,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
`ifdef MDU_MADD_EN
    localparam logic [2:0] OP_MADD  = 3'd7;
`endif

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [31:0]       hi_q;
    logic [31:0]       lo_q;
    logic [63:0]       pend_q;
    logic              pend_vld_q;

    logic [63:0]       pend_d;
    logic              pend_vld_d;
    logic [CNT_W-1:0]  cnt_load;
    logic              launch;

    logic [63:0]       a_sx;
    logic [63:0]       b_sx;
    logic [63:0]       a_zx;
    logic [63:0]       b_zx;
    logic [63:0]       prod_s;
    logic [63:0]       prod_u;
    logic [31:0]       quot_s;
    logic [31:0]       rem_s;
    logic [31:0]       quot_u;
    logic [31:0]       rem_u;
    logic              div_by_zero;

    // Operand extension and arithmetic; 64-bit products wrap to the signed result
    always_comb begin
        a_sx        = {{32{rs_data[31]}}, rs_data};
        b_sx        = {{32{rt_data[31]}}, rt_data};
        a_zx        = {32'd0, rs_data};
        b_zx        = {32'd0, rt_data};
        prod_s      = a_sx * b_sx;
        prod_u      = a_zx * b_zx;
        div_by_zero = (rt_data == 32'd0);
        quot_s      = 32'($signed(rs_data) / $signed(rt_data));
        rem_s       = 32'($signed(rs_data) % $signed(rt_data));
        quot_u      = rs_data / rt_data;
        rem_u       = rs_data % rt_data;
    end

    // Decode the start op into a pending result, its commit flag and latency
    always_comb begin
        pend_d     = pend_q;
        pend_vld_d = 1'b0;
        cnt_load   = '0;
        launch     = 1'b0;
        case (md_op)
            OP_MULT: begin
                pend_d     = prod_s;
                pend_vld_d = 1'b1;
                cnt_load   = MULT_LOAD;
                launch     = 1'b1;
            end
            OP_MULTU: begin
                pend_d     = prod_u;
                pend_vld_d = 1'b1;
                cnt_load   = MULT_LOAD;
                launch     = 1'b1;
            end
            OP_DIV: begin
                pend_d     = {rem_s, quot_s};
                pend_vld_d = !div_by_zero;
                cnt_load   = DIV_LOAD;
                launch     = 1'b1;
            end
            OP_DIVU: begin
                pend_d     = {rem_u, quot_u};
                pend_vld_d = !div_by_zero;
                cnt_load   = DIV_LOAD;
                launch     = 1'b1;
            end
`ifdef MDU_MADD_EN
            OP_MADD: begin
                pend_d     = {hi_q, lo_q} + prod_s;
                pend_vld_d = 1'b1;
                cnt_load   = MULT_LOAD;
                launch     = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // Sequencer: launch from IDLE, count out the latency in BUSY, commit on the last edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            pend_q     <= 64'd0;
            pend_vld_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (launch) begin
                            pend_q     <= pend_d;
                            pend_vld_q <= pend_vld_d;
                            cnt_q      <= cnt_load;
                            state_q    <= BUSY;
                        end else if (md_op == OP_MTHI) begin
                            hi_q <= rs_data;
                        end else if (md_op == OP_MTLO) begin
                            lo_q <= rs_data;
                        end
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_q    <= IDLE;
                        pend_vld_q <= 1'b0;
                        if (pend_vld_q) begin
                            hi_q <= pend_q[63:32];
                            lo_q <= pend_q[31:0];
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy     = (state_q == BUSY);
    assign md_stall = d_md_use & (busy | start);
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule
